// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Grants bursts of up to MAX_BURST beats; handoff between bursts has no idle cycle.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          fifo_full,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   last_grant, last_n;
    logic [GW-1:0]   grant_n;
    logic [CW-1:0]   beat_cnt, cnt_n;
    logic [GW-1:0]   win;
    logic            found;
    logic            xfer;
    logic            burst_end;
    int              idx;

    // Search order last_grant+1 .. last_grant; the holder is considered last
    always_comb begin
        found = 1'b0;
        win   = last_grant;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_grant) + i) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant_id;
        last_n    = last_grant;
        cnt_n     = beat_cnt;
        xfer      = 1'b0;
        burst_end = 1'b0;
        wr        = 1'b0;
        req_ready = '0;
        w_data    = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BURST;
                    grant_n = win;
                    last_n  = win;
                    cnt_n   = '0;
                end
            end
            BURST: begin
                req_ready[grant_id] = ~fifo_full;
                w_data    = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                xfer      = req_valid[grant_id] & ~fifo_full;
                wr        = xfer;
                burst_end = (xfer && beat_cnt == CW'(MAX_BURST - 1))
                          || !req_valid[grant_id];
                if (xfer)
                    cnt_n = beat_cnt + CW'(1);
                if (burst_end) begin
                    cnt_n = '0;
                    if (found) begin
                        grant_n = win;
                        last_n  = win;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(N_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_n;
            grant_id   <= grant_n;
            last_grant <= last_n;
            beat_cnt   <= cnt_n;
        end
    end

    assign busy = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            wr;
    logic [DW-1:0]   w_data;
    logic [GW-1:0]   grant_id;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arbiter #(
        .N_REQ(N),
        .DATA_WIDTH(DW),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .wr(wr),
        .w_data(w_data),
        .grant_id(grant_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    always @(negedge clk)
        check("no_wr_when_full", 32'(wr & fifo_full), 0);

    initial begin
        // reset state
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_wr", 32'(wr), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_wdata", 32'(w_data), 0);
        check("rst_grant", 32'(grant_id), 0);

        // T1: requester 0 streams 5, 8, 12
        do_reset();
        req_valid = 4'b0001;
        set_data(0, 8'd5);
        sample();
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_wr", 32'(wr), 0);
        tick();
        sample();
        check("t1_b1_busy", 32'(busy), 1);
        check("t1_b1_wr", 32'(wr), 1);
        check("t1_b1_data", 32'(w_data), 5);
        check("t1_b1_ready", 32'(req_ready), 1);
        check("t1_b1_grant", 32'(grant_id), 0);
        tick();
        set_data(0, 8'd8);
        sample();
        check("t1_b2_wr", 32'(wr), 1);
        check("t1_b2_data", 32'(w_data), 8);
        tick();
        set_data(0, 8'd12);
        sample();
        check("t1_b3_wr", 32'(wr), 1);
        check("t1_b3_data", 32'(w_data), 12);
        tick();
        req_valid = '0;
        sample();
        check("t1_drop_wr", 32'(wr), 0);
        check("t1_drop_busy", 32'(busy), 1);
        tick();
        sample();
        check("t1_idle_end", 32'(busy), 0);

        // T2: all four requesters continuously valid
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < N; i++)
            set_data(i, DW'(8'hA0 + i));
        sample();
        check("t2_idle", 32'(busy), 0);
        for (int c = 0; c < 20; c++) begin
            tick();
            sample();
            check("t2_wr", 32'(wr), 1);
            check("t2_grant", 32'(grant_id), 32'((c / 4) % 4));
            check("t2_data", 32'(w_data), 32'(8'hA0 + (c / 4) % 4));
        end
        tick();
        req_valid = '0;
        sample();
        check("t2_next_grant", 32'(grant_id), 1);
        check("t2_drop_wr", 32'(wr), 0);
        tick();
        sample();
        check("t2_end_idle", 32'(busy), 0);

        // T3: full stall mid-burst on requester 1
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'd31);
        sample();
        tick();
        sample();
        check("t3_b1_wr", 32'(wr), 1);
        check("t3_b1_grant", 32'(grant_id), 1);
        check("t3_b1_data", 32'(w_data), 31);
        tick();
        set_data(1, 8'd32);
        sample();
        check("t3_b2_wr", 32'(wr), 1);
        check("t3_b2_data", 32'(w_data), 32);
        tick();
        set_data(1, 8'd33);
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t3_full_wr", 32'(wr), 0);
            check("t3_full_ready", 32'(req_ready), 0);
            check("t3_full_grant", 32'(grant_id), 1);
            check("t3_full_busy", 32'(busy), 1);
            tick();
        end
        fifo_full = 1'b0;
        sample();
        check("t3_b3_wr", 32'(wr), 1);
        check("t3_b3_data", 32'(w_data), 33);
        check("t3_b3_ready", 32'(req_ready), 2);
        tick();
        set_data(1, 8'd34);
        sample();
        check("t3_b4_wr", 32'(wr), 1);
        check("t3_b4_data", 32'(w_data), 34);
        tick();
        req_valid = '0;
        sample();
        check("t3_post_wr", 32'(wr), 0);
        tick();
        sample();
        check("t3_end_idle", 32'(busy), 0);

        // T4: round-robin from last_grant=1, then wrap from 3
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'd11);
        sample();
        tick();
        sample();
        check("t4_pre_grant", 32'(grant_id), 1);
        tick();
        req_valid = '0;
        sample();
        tick();
        sample();
        check("t4_pre_idle", 32'(busy), 0);
        tick();
        req_valid = 4'b1010;
        set_data(3, 8'd33);
        sample();
        tick();
        sample();
        check("t4_grant3", 32'(grant_id), 3);
        check("t4_wr3", 32'(wr), 1);
        check("t4_data3", 32'(w_data), 33);
        check("t4_ready3", 32'(req_ready), 8);
        tick();
        req_valid = '0;
        sample();
        tick();
        req_valid = 4'b0100;
        set_data(2, 8'd22);
        sample();
        check("t4_mid_idle", 32'(busy), 0);
        tick();
        sample();
        check("t4_grant2", 32'(grant_id), 2);
        check("t4_data2", 32'(w_data), 22);
        tick();
        req_valid = '0;
        tick();

        // T5: asynchronous reset during the second beat
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < N; i++)
            set_data(i, DW'(i + 1));
        sample();
        tick();
        sample();
        check("t5_b1_wr", 32'(wr), 1);
        tick();
        #2;
        check("t5_b2_wr", 32'(wr), 1);
        check("t5_b2_grant", 32'(grant_id), 0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_wr", 32'(wr), 0);
        check("t5_rst_ready", 32'(req_ready), 0);
        check("t5_rst_busy", 32'(busy), 0);
        tick();
        reset_n = 1'b1;
        sample();
        check("t5_rel_idle", 32'(busy), 0);
        tick();
        sample();
        check("t5_rel_grant", 32'(grant_id), 0);
        check("t5_rel_wr", 32'(wr), 1);
        check("t5_rel_busy", 32'(busy), 1);

        // T6: grant while full, write when full clears
        do_reset();
        fifo_full = 1'b1;
        req_valid = 4'b0100;
        set_data(2, 8'd17);
        sample();
        check("t6_idle", 32'(busy), 0);
        tick();
        sample();
        check("t6_busy", 32'(busy), 1);
        check("t6_grant", 32'(grant_id), 2);
        check("t6_full_wr", 32'(wr), 0);
        check("t6_full_ready", 32'(req_ready), 0);
        tick();
        sample();
        check("t6_full_wr2", 32'(wr), 0);
        tick();
        fifo_full = 1'b0;
        sample();
        check("t6_wr", 32'(wr), 1);
        check("t6_data", 32'(w_data), 17);
        check("t6_ready", 32'(req_ready), 4);
        tick();
        req_valid = '0;
        tick();
        sample();
        check("t6_end_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
